// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared defaults and address type for the program counter
//
// Purpose: default address width, sequential step and reset address used by
// program_counter and pc_incr, plus the matching address typedef.
// Ports: none (package).
// Optional feature macro used by the slice: PC_MISALIGN_EN.

package pc_pkg;

  localparam int ADDR_W = 32;
  localparam int PC_STEP = 4;
  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

  typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/pc_incr.sv
// rtl/pc_incr.sv - combinational PC incrementer with modulo-2^ADDR_W wrap
//
// Purpose: produces pc + PC_STEP; the carry out of the top bit is dropped so
// the address wraps silently.
// Ports:
//   pc      in  ADDR_W  current program counter
//   pcNext  out ADDR_W  pc + PC_STEP (wrapped)

module pc_incr #(
  parameter int ADDR_W = pc_pkg::ADDR_W,
  parameter int PC_STEP = pc_pkg::PC_STEP
) (
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pcNext
);

  import pc_pkg::*;

  assign pcNext = pc + ADDR_W'(PC_STEP);

endmodule

// File: rtl/program_counter.sv
// rtl/program_counter.sv - fetch-stage program counter register
//
// Purpose: holds the current instruction address; every rising clk edge it
// either advances by PC_STEP or loads the branch target.
// Optional feature macro: PC_MISALIGN_EN (branch targets are word-aligned and
// a registered misaligned flag is reported).
// Ports:
//   clk         in  1       clock, rising edge
//   reset       in  1       asynchronous active-low reset
//   addrIn      in  ADDR_W  branch target address
//   branch      in  1       1 = load addrIn, 0 = advance by PC_STEP
//   addrOut     out ADDR_W  current PC (registered)
//   misaligned  out 1       only with PC_MISALIGN_EN: previous branch target
//                           had nonzero low bits

module program_counter #(
  parameter int ADDR_W = pc_pkg::ADDR_W,
  parameter int PC_STEP = pc_pkg::PC_STEP,
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(pc_pkg::RESET_ADDR)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addrIn,
  input  logic              branch,
  output logic [ADDR_W-1:0] addrOut
`ifdef PC_MISALIGN_EN
  ,
  output logic              misaligned
`endif
);

  import pc_pkg::*;

  logic [ADDR_W-1:0] seqAddr;
  logic [ADDR_W-1:0] branchAddr;
  logic [ADDR_W-1:0] nextAddr;

  pc_incr #(
    .ADDR_W (ADDR_W),
    .PC_STEP(PC_STEP)
  ) u_incr (
    .pc    (addrOut),
    .pcNext(seqAddr)
  );

`ifdef PC_MISALIGN_EN
  // Targets are forced onto a word boundary; the dropped bits are flagged.
  assign branchAddr = {addrIn[ADDR_W-1:2], 2'b00};
`else
  assign branchAddr = addrIn;
`endif

  always_comb begin
    nextAddr = seqAddr;
    if (branch) begin
      nextAddr = branchAddr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addrOut <= RESET_ADDR;
    end else begin
      addrOut <= nextAddr;
    end
  end

`ifdef PC_MISALIGN_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misaligned <= 1'b0;
    end else begin
      misaligned <= branch && (addrIn[1:0] != 2'b00);
    end
  end
`endif

endmodule

// File: tb/tb_program_counter.sv
// tb/tb_program_counter.sv - directed self-checking bench for program_counter

module tb_program_counter;

  logic        clk;
  logic        reset;
  logic [31:0] addrIn;
  logic        branch;
  logic [31:0] addrOut;
`ifdef PC_MISALIGN_EN
  logic        misaligned;
`endif

  int compared = 0;
  int mismatched = 0;

  program_counter dut (
    .clk    (clk),
    .reset  (reset),
    .addrIn (addrIn),
    .branch (branch),
    .addrOut(addrOut)
`ifdef PC_MISALIGN_EN
    ,
    .misaligned(misaligned)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive inputs, take one rising edge, sample 1ns later and compare addrOut.
  task automatic step(input logic br, input logic [31:0] tgt, input logic [31:0] exp,
                      input string tag);
    branch = br;
    addrIn = tgt;
    @(posedge clk);
    #1;
    check(tag, addrOut, exp);
  endtask

  initial begin
    logic [31:0] expPc;

    reset  = 1'b0;
    branch = 1'b0;
    addrIn = 32'h0;
    #2;
    check("reset_async", addrOut, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", addrOut, 32'h0);
`ifdef PC_MISALIGN_EN
    check("reset_misaligned", {31'b0, misaligned}, 32'h0);
`endif

    // Release between edges; the first edge afterwards gives RESET_ADDR + 4.
    reset = 1'b1;
    #1;
    check("release_no_edge", addrOut, 32'h0);
    expPc = 32'h0;
    for (int i = 0; i < 11; i++) begin
      expPc = expPc + 32'd4;
      step(1'b0, 32'h0, expPc, "seq_incr");
    end
    check("seq_at_44", addrOut, 32'd44);

    // Single branch then sequential.
    step(1'b1, 32'hCAFE_F00C, 32'hCAFE_F00C, "branch_load");
    step(1'b0, 32'h0, 32'hCAFE_F010, "branch_then_seq");

    // Wrap-around at the top of the address space.
    step(1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFF8, "wrap_branch");
    step(1'b0, 32'h0, 32'hFFFF_FFFC, "wrap_fffc");
    step(1'b0, 32'h0, 32'h0000_0000, "wrap_zero");
    step(1'b0, 32'h0, 32'h0000_0004, "wrap_four");

    // Asynchronous reset mid-run, with a pending branch that must be discarded.
    step(1'b1, 32'h100, 32'h100, "pre_reset_load");
    branch = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_clear", addrOut, 32'h0);
    branch = 1'b1;
    addrIn = 32'h40;
    @(posedge clk);
    #1;
    check("reset_overrides_branch_1", addrOut, 32'h0);
    @(posedge clk);
    #1;
    check("reset_overrides_branch_2", addrOut, 32'h0);
    reset = 1'b1;

    // Back-to-back branches.
    step(1'b1, 32'h10, 32'h10, "b2b_10");
    step(1'b1, 32'h20, 32'h20, "b2b_20");
    step(1'b1, 32'h30, 32'h30, "b2b_30");
    step(1'b0, 32'h0, 32'h34, "b2b_then_seq");

    // addrIn is ignored while branch is low.
    step(1'b0, 32'hDEAD_BEEC, 32'h38, "addrin_ignored");

    // Misaligned target.
`ifdef PC_MISALIGN_EN
    step(1'b1, 32'h0000_0102, 32'h0000_0100, "misalign_load");
    check("misalign_flag_high", {31'b0, misaligned}, 32'h1);
    step(1'b0, 32'h0, 32'h0000_0104, "misalign_then_seq");
    check("misalign_flag_low", {31'b0, misaligned}, 32'h0);
    step(1'b1, 32'h0000_0200, 32'h0000_0200, "aligned_load");
    check("aligned_flag_low", {31'b0, misaligned}, 32'h0);
`else
    step(1'b1, 32'h0000_0102, 32'h0000_0102, "verbatim_load");
    step(1'b0, 32'h0, 32'h0000_0106, "verbatim_then_seq");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
